// File: rtl/capstone_pkg.sv
// Shared types and helpers for the word serializer/deserializer datapath.
package capstone_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    // Index width that stays at least one bit wide, even for a single-entry range.
    function automatic int clog2_min1(input int n);
        int r;
        if (n <= 1) begin
            r = 1;
        end else begin
            r = $clog2(n);
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX counter with clear and clock enable; wrap flags the terminal count.
module mod_counter
    import capstone_pkg::*;
#(
    parameter int MAX = 3,
    localparam int W  = clog2_min1(MAX)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_r;

    // Counter register: clear has priority over increment, wraps at MAX-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {W{1'b0}};
        end else if (ce) begin
            if (clr) begin
                count_r <= {W{1'b0}};
            end else if (inc) begin
                if (count_r == LAST) begin
                    count_r <= {W{1'b0}};
                end else begin
                    count_r <= count_r + W'(1);
                end
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    // wrap is a level: high while the counter sits on its terminal value.
    always_comb begin
        count = count_r;
        wrap  = (count_r == LAST);
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, serial-out word serializer, LSW first, with valid/ready on both sides.
module word_serializer
    import capstone_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SIZE*WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int IDXW = clog2_min1(SIZE);

    ser_state_t       state_r;
    logic [WIDTH-1:0] words_r [SIZE];
    logic [WIDTH-1:0] out_data_r;
    logic [IDXW-1:0]  index_s;
    logic [IDXW-1:0]  next_index_s;
    logic [WIDTH-1:0] next_word_s;
    logic             last_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             inc_s;

    // Handshakes: in_ready may look through to out_ready so vectors chain without a bubble.
    always_comb begin
        out_valid  = ce & (state_r == S_SHIFT);
        in_ready   = ce & reset_n &
                     ((state_r == S_IDLE) | (out_valid & out_ready & last_s));
        out_xfer_s = out_valid & out_ready;
        in_xfer_s  = in_valid & in_ready;
        inc_s      = out_xfer_s & ~last_s;
        out_last   = out_valid & last_s;
        busy       = (state_r == S_SHIFT);
        out_data   = out_data_r;
    end

    mod_counter #(
        .MAX (SIZE)
    ) u_index (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .inc     (inc_s),
        .clr     (in_xfer_s),
        .count   (index_s),
        .wrap    (last_s)
    );

    // Lookahead word; the out-of-range case only arises on the last word and is never used.
    always_comb begin
        next_index_s = index_s + IDXW'(1);
        if (int'(next_index_s) < SIZE) begin
            next_word_s = words_r[next_index_s];
        end else begin
            next_word_s = words_r[0];
        end
    end

    // Word buffer: captured whole on every accepted input vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SIZE; k++) begin
                words_r[k] <= {WIDTH{1'b0}};
            end
        end else if (in_xfer_s) begin
            for (int k = 0; k < SIZE; k++) begin
                words_r[k] <= in_data[k*WIDTH +: WIDTH];
            end
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                words_r[k] <= words_r[k];
            end
        end
    end

    // Control FSM and registered output word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            out_data_r <= {WIDTH{1'b0}};
        end else if (ce) begin
            case (state_r)
                S_IDLE: begin
                    if (in_xfer_s) begin
                        out_data_r <= in_data[WIDTH-1:0];
                        state_r    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (in_xfer_s) begin
                        out_data_r <= in_data[WIDTH-1:0];
                    end else if (out_xfer_s) begin
                        if (!last_s) begin
                            out_data_r <= next_word_s;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
